// File: rtl/fetch_stage.sv
// fetch_stage
// PC generation, instruction-memory request handshake and IF/ID pipeline
// register for the 16-bit core. It sits directly upstream of hazard/decode.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   stall        hold IF/ID and the fetch PC (hazard unit Stall)
//   redirect_en  flush the fetch pipe and load redirect_pc
//   redirect_pc  branch/JMP/JAL/JR target
//   imem_req     instruction-memory request (registered)
//   imem_addr    request address (the fetch PC)
//   imem_ack     read data valid this cycle
//   imem_rdata   read data
//   inst_d       IF/ID instruction
//   pc_d         IF/ID PC of inst_d
//   valid_d      inst_d is a real instruction (0 = bubble)
//
// Optional feature (macro FETCH_PERF_EN): adds 16-bit saturating counters
//   fetch_cnt (valid_d loaded with 1), stall_cnt (stall cycles) and
//   flush_cnt (redirect cycles).

module fetch_stage #(
    parameter int unsigned            PC_W     = 16,
    parameter int unsigned            INST_W   = 16,
    parameter logic [PC_W-1:0]        RESET_PC = '0,
    parameter logic [INST_W-1:0]      NOP_INST = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect_en,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_rdata,
    output logic [INST_W-1:0] inst_d,
    output logic [PC_W-1:0]   pc_d,
    output logic              valid_d
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]       fetch_cnt,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       flush_cnt
`endif
);

    typedef enum logic {
        S_REQ  = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t              state;
    logic [PC_W-1:0]     pc_f;
    logic [INST_W-1:0]   buf_inst;
    logic [PC_W-1:0]     buf_pc;
    logic                ack_ok;

    // An ack only counts while a request is actually outstanding, so a late
    // ack after reset (or while holding) is ignored.
    assign ack_ok    = imem_ack & imem_req;
    assign imem_addr = pc_f;

    // The hold buffer is full exactly when the FSM is in S_HOLD, so leaving
    // S_HOLD is what clears it; no separate valid flag is kept.
    // imem_req is registered so it stays low throughout reset and rises on
    // the first clock edge after release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_REQ;
            imem_req <= 1'b0;
            pc_f     <= RESET_PC;
            buf_inst <= NOP_INST;
            buf_pc   <= '0;
            inst_d   <= NOP_INST;
            pc_d     <= '0;
            valid_d  <= 1'b0;
        end else begin
            case (state)
                S_REQ: begin
                    imem_req <= 1'b1;
                    if (redirect_en) begin
                        pc_f    <= redirect_pc;
                        inst_d  <= NOP_INST;
                        valid_d <= 1'b0;
                    end else if (ack_ok && !stall) begin
                        inst_d  <= imem_rdata;
                        pc_d    <= pc_f;
                        valid_d <= 1'b1;
                        pc_f    <= pc_f + 1'b1;
                    end else if (ack_ok && stall) begin
                        // Data arrived while decode is held: park it.
                        buf_inst <= imem_rdata;
                        buf_pc   <= pc_f;
                        pc_f     <= pc_f + 1'b1;
                        state    <= S_HOLD;
                        imem_req <= 1'b0;
                    end else if (!stall) begin
                        inst_d  <= NOP_INST;
                        valid_d <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (redirect_en) begin
                        // A resolved branch overrides the hold; parked data
                        // belongs to the flushed path and is dropped.
                        pc_f     <= redirect_pc;
                        inst_d   <= NOP_INST;
                        valid_d  <= 1'b0;
                        state    <= S_REQ;
                        imem_req <= 1'b1;
                    end else if (!stall) begin
                        inst_d   <= buf_inst;
                        pc_d     <= buf_pc;
                        valid_d  <= 1'b1;
                        state    <= S_REQ;
                        imem_req <= 1'b1;
                    end else begin
                        imem_req <= 1'b0;
                    end
                end
                default: begin
                    state    <= S_REQ;
                    imem_req <= 1'b1;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic load_valid;

    // Mirrors the two FSM paths that load valid_d with 1.
    assign load_valid = !redirect_en && !stall &&
                        ((state == S_REQ && ack_ok) || (state == S_HOLD));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (load_valid && fetch_cnt != 16'hFFFF)
                fetch_cnt <= fetch_cnt + 16'd1;
            if (stall && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
            if (redirect_en && flush_cnt != 16'hFFFF)
                flush_cnt <= flush_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- PC generation, instruction-memory request handshake and IF/ID pipeline register for the 16-bit core.
- Sits directly upstream of the hazard/decode logic.
- Consumes the hazard unit's Stall (hold) and a resolved control-flow redirect (flush plus new PC).
- Produces the fetched instruction word and its PC for the decode stage.

Parameters:
- PC_W, 16, PC/instruction-address width (word-addressed).
- INST_W, 16, instruction width.
- RESET_PC, 0, PC value loaded on reset.
- NOP_INST, 0, instruction word inserted as a bubble.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- stall  in  1  hold IF/ID and the fetch PC (from the hazard Stall).
- redirect_en  in  1  flush the fetch pipe and load redirect_pc.
- redirect_pc  in  PC_W  target of branch/JMP/JAL/JR.
- imem_req  out  1  instruction-memory request.
- imem_addr  out  PC_W  request address.
- imem_ack  in  1  read data valid this cycle.
- imem_rdata  in  INST_W  read data.
- inst_d  out  INST_W  IF/ID instruction.
- pc_d  out  PC_W  IF/ID PC of inst_d.
- valid_d  out  1  inst_d is a real instruction; 0 means bubble.

Behaviour:
- Reset (rst low, asynchronous), all outputs and state are forced to:
  - pc_f=RESET_PC, state=S_REQ, hold buffer empty.
  - inst_d=NOP_INST, pc_d=0, valid_d=0.
  - imem_req=0 while rst is low.
- imem_req rises in the first cycle after rst deasserts.
- Reset mid-request abandons that request; a late ack is ignored because imem_req is 0.
- imem_addr = pc_f whenever imem_req=1.
- The address is stable until ack, except on the redirect cycle. The memory must tolerate an unacked address change.
- pc_f increments modulo 2^PC_W; 0xFFFF+1 wraps to 0x0000.
- State S_REQ: imem_req=1. Per cycle, first match wins:
  1. redirect_en:
     - pc_f<=redirect_pc; inst_d<=NOP_INST; valid_d<=0; buffer cleared.
     - Any imem_ack this cycle is discarded; stay in S_REQ.
  2. imem_ack & !stall:
     - inst_d<=imem_rdata; pc_d<=pc_f; valid_d<=1; pc_f<=pc_f+1.
  3. imem_ack & stall:
     - IF/ID holds; the hold buffer captures {imem_rdata, pc_f}.
     - pc_f<=pc_f+1; go to S_HOLD.
  4. !imem_ack & stall: IF/ID and pc_f hold.
  5. !imem_ack & !stall: inst_d<=NOP_INST, valid_d<=0 (bubble); pc_d holds.
- State S_HOLD: imem_req=0.
  - redirect_en: same as rule 1 above (buffer dropped), then go to S_REQ.
  - Otherwise, when !stall: IF/ID<=buffer with valid_d=1, buffer cleared, go to S_REQ.
  - Otherwise (stall): everything holds.
- Latency:
  - Ack in cycle N with no stall gives inst_d valid in cycle N+1.
  - Back-to-back single-cycle acks give one instruction per cycle.
- Simultaneous redirect_en and stall: redirect wins, because a branch resolved downstream overrides a hold of the flushed slot.
- Redirect followed by stall in the next cycle: the new target is still requested; the returned instruction goes to the hold buffer.

Optional Feature:
- Macro: FETCH_PERF_EN.
- When defined, three extra outputs are added: fetch_cnt, stall_cnt and flush_cnt, each 16 bits.
  - All three are saturating counters, reset to 0.
  - fetch_cnt counts cycles where valid_d is loaded with 1.
  - stall_cnt counts cycles with stall=1.
  - flush_cnt counts cycles with redirect_en=1.
  - Counters saturate at 0xFFFF.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset then streaming:
  - Stimulus: rst low 3 cycles, release; imem_ack=1 every cycle; imem_rdata=0x1000+addr.
  - Response: imem_addr 0,1,2,…; inst_d 0x1000,0x1001,… with pc_d 0,1,… one cycle later; valid_d=1 from the 2nd cycle after release.
- Stall with buffer:
  - Stimulus: stall=1 for 3 cycles while ack returns addr 5.
  - Response: IF/ID holds the addr-4 instruction; imem_req=0 for the 2 remaining stall cycles.
  - Response after stall drops: inst_d=0x1005, pc_d=5; next request is addr 6.
- Redirect:
  - Stimulus: redirect_en=1 with redirect_pc=0x0040 while ack returns addr 8.
  - Response: the addr-8 data is discarded; valid_d=0 next cycle; the following request is addr 0x0040.
- Redirect + stall same cycle:
  - Response: flush happens; pc_f=redirect_pc; valid_d=0; S_HOLD is exited.
- Slow memory:
  - Stimulus: ack every 3rd cycle, no stall.
  - Response: valid_d pattern 1,0,0,1,0,0; imem_addr stable during each wait.
- Wrap and reset mid-op:
  - Stimulus: redirect to 0xFFFF, acks continue.
  - Response: addresses 0xFFFF then 0x0000.
  - Stimulus: assert rst while in S_HOLD.
  - Response: immediate return to the reset values, and the buffer is not delivered.
